dac_ddr_fmt: RTL and testbench

Multi-channel DDR DAC output formatter: the parametrised successor to the single-bus DDR output cells. It drives `nch` DAC buses of `width` bits each. For every bus it converts two's-complement samples to offset binary (optional), and it adds mute, test-ramp and guarded mode switching. It also detects input starvation, with hold-last-sample and auto-mute. It sits between the DSP datapath and the FPGA output pins, with one DDR output cell per DAC bit.

---
 rtl/dac_ddr_fmt_pkg.sv | 24 ++
 rtl/dac_ddr_fmt_ddr_out_cell.sv | 43 ++++
 rtl/dac_ddr_fmt.sv | 153 +++++++++++++++
 tb/tb_dac_ddr_fmt.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dac_ddr_fmt_pkg.sv
// Shared types for the DDR DAC formatter: requested-mode codes, FSM state encoding, mode decode.
package dac_ddr_fmt_pkg;

  localparam logic [1:0] MODE_MUTE = 2'd0;
  localparam logic [1:0] MODE_RUN  = 2'd1;
  localparam logic [1:0] MODE_TEST = 2'd2;

  typedef enum logic [1:0] {
    ST_MUTE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_TEST  = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

  // The reserved code 3 folds into MUTE.
  function automatic state_t mode_to_state(input logic [1:0] m);
    case (m)
      MODE_RUN:  return ST_RUN;
      MODE_TEST: return ST_TEST;
      default:   return ST_MUTE;
    endcase
  endfunction

endpackage

// File: rtl/dac_ddr_fmt_ddr_out_cell.sv
// One DAC pin DDR register: d0 launched on the rising edge, d1 on the falling edge.
// Async reset forces the pin to rst_val immediately; no flow control.
module ddr_out_cell #(
  parameter bit rst_val = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d0,
  input  logic d1,
  output logic q
);

`ifdef DAC_DDR_FDDRRSE
  // Vendor DDR flop; the set/reset pair selects this bit's midscale reset value.
  FDDRRSE u_fddr (
    .Q  (q),
    .C0 (clk),
    .C1 (~clk),
    .CE (1'b1),
    .D0 (d0),
    .D1 (d1),
    .R  (~rst_n & ~rst_val),
    .S  (~rst_n & rst_val)
  );
`else
  logic q_p;
  logic q_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_p <= rst_val;
    else        q_p <= d0;
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) q_n <= rst_val;
    else        q_n <= d1;
  end

  // High phase shows the rising-edge half, low phase the falling-edge half.
  assign q = clk ? q_p : q_n;
`endif

endmodule

// File: rtl/dac_ddr_fmt.sv
// Multi-channel DDR DAC formatter: MUTE/RUN/TEST with midscale guard on mode change, starvation hold and auto-mute.
// data0 reaches dac one posedge after capture, data1 one negedge later; no backpressure, invalid input repeats the last pair.
module dac_ddr_fmt
  import dac_ddr_fmt_pkg::*;
#(
  parameter int width      = 16,
  parameter int nch        = 2,
  parameter bit signed_in  = 1'b1,
  parameter int guard_len  = 8,
  parameter int starve_lim = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic                   mode_stb,
  input  logic                   in_valid,
  input  logic [nch*width-1:0]   data0,
  input  logic [nch*width-1:0]   data1,
  output logic [nch*width-1:0]   dac,
  output logic                   busy,
  output logic                   starved,
  output logic [15:0]            uf_cnt
);

  localparam int W  = nch * width;
  localparam int GW = (guard_len > 1) ? $clog2(guard_len) : 1;
  localparam int SW = $clog2(starve_lim + 1);

  localparam logic [width-1:0] MID       = {1'b1, {(width-1){1'b0}}};
  localparam logic [W-1:0]     MID_ALL   = {nch{MID}};
  localparam logic [W-1:0]     SIGN_MASK = signed_in ? MID_ALL : '0;
  localparam logic [width-1:0] RAMP_ONE  = width'(1);
  localparam logic [width-1:0] RAMP_TWO  = width'(2);

  state_t         state_q, state_d;
  state_t         tgt_q, tgt_d;
  logic [GW-1:0]  gcnt_q, gcnt_d;
  logic [SW-1:0]  scnt_q, scnt_d;
  logic           starved_d;
  logic [15:0]    uf_d;
  logic           starve_trip;

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    gcnt_d      = gcnt_q;
    scnt_d      = '0;
    starved_d   = starved;
    uf_d        = uf_cnt;
    starve_trip = 1'b0;

    if (state_q == ST_RUN && !in_valid) begin
      scnt_d      = scnt_q + SW'(1);
      starve_trip = (scnt_d == SW'(starve_lim));
      if (uf_cnt != 16'hFFFF) uf_d = uf_cnt + 16'd1;
    end

    case (state_q)
      ST_GUARD: begin
        if (gcnt_q == '0) state_d = tgt_q;
        else              gcnt_d  = gcnt_q - GW'(1);
      end
      ST_RUN: begin
        // Starvation drops straight to MUTE without a guard interval.
        if (starve_trip) begin
          state_d   = ST_MUTE;
          starved_d = 1'b1;
        end
      end
      default: ;
    endcase

    // A strobe overrides everything, including a concurrent starvation trip.
    if (mode_stb) begin
      tgt_d     = mode_to_state(mode);
      gcnt_d    = GW'(guard_len - 1);
      state_d   = ST_GUARD;
      starved_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_MUTE;
      tgt_q   <= ST_MUTE;
      gcnt_q  <= '0;
      scnt_q  <= '0;
      starved <= 1'b0;
      uf_cnt  <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      gcnt_q  <= gcnt_d;
      scnt_q  <= scnt_d;
      starved <= starved_d;
      uf_cnt  <= uf_d;
    end
  end

  assign busy = (state_q == ST_GUARD);

  logic [width-1:0] ramp_q;
  logic [width-1:0] ramp_p1;
  logic [W-1:0]     st0_q, st1_q, st1_n_q;

  assign ramp_p1 = ramp_q + RAMP_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st0_q  <= MID_ALL;
      st1_q  <= MID_ALL;
      ramp_q <= '0;
    end else begin
      // Ramp restarts from zero whenever TEST is (re)entered.
      ramp_q <= (state_q == ST_TEST) ? ramp_q + RAMP_TWO : '0;
      case (state_q)
        ST_RUN: begin
          if (in_valid) begin
            st0_q <= data0 ^ SIGN_MASK;
            st1_q <= data1 ^ SIGN_MASK;
          end
        end
        ST_TEST: begin
          st0_q <= {nch{ramp_q}};
          st1_q <= {nch{ramp_p1}};
        end
        default: begin
          st0_q <= MID_ALL;
          st1_q <= MID_ALL;
        end
      endcase
    end
  end

  // Second half retimed to the falling edge before it feeds the cell's low-phase input.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) st1_n_q <= MID_ALL;
    else        st1_n_q <= st1_q;
  end

  for (genvar i = 0; i < W; i++) begin : g_bit
    ddr_out_cell #(
      .rst_val((i % width) == (width - 1))
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .d0    (st0_q[i]),
      .d1    (st1_n_q[i]),
      .q     (dac[i])
    );
  end

endmodule

// File: tb/tb_dac_ddr_fmt.sv
// Bench for dac_ddr_fmt: two instances (2ch signed, 3ch offset-binary) share control and are
// compared every half-cycle against a mode-level reference model.
module tb_dac_ddr_fmt;

  localparam int          GUARD_LEN  = 8;
  localparam int          STARVE_LIM = 16;
  localparam logic [15:0] MID        = 16'h8000;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic [1:0]  mode     = 2'd0;
  logic        mode_stb = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] d0a = '0, d1a = '0;
  logic [47:0] d0b = '0, d1b = '0;
  logic [31:0] dac_a;
  logic [47:0] dac_b;
  logic        busy_a, busy_b, starved_a, starved_b;
  logic [15:0] uf_a, uf_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dac_ddr_fmt #(.width(16), .nch(2), .signed_in(1'b1), .guard_len(GUARD_LEN), .starve_lim(STARVE_LIM)) u_a (
    .clk(clk), .rst_n(rst_n), .mode(mode), .mode_stb(mode_stb), .in_valid(in_valid),
    .data0(d0a), .data1(d1a), .dac(dac_a), .busy(busy_a), .starved(starved_a), .uf_cnt(uf_a));

  dac_ddr_fmt #(.width(16), .nch(3), .signed_in(1'b0), .guard_len(GUARD_LEN), .starve_lim(STARVE_LIM)) u_b (
    .clk(clk), .rst_n(rst_n), .mode(mode), .mode_stb(mode_stb), .in_valid(in_valid),
    .data0(d0b), .data1(d1b), .dac(dac_b), .busy(busy_b), .starved(starved_b), .uf_cnt(uf_b));

  // Reference model: effective mode, cycles of guard left, and the pair most recently chosen.
  int          m_cur, m_tgt, m_guard, m_starve, m_uf;
  bit          m_starved;
  logic [15:0] m_r;
  logic [31:0] sa0, sa1, ea0, ea1;
  logic [47:0] sb0, sb1, eb0, eb1;
  logic [31:0] obs_a0, obs_a1;
  logic [47:0] obs_b0, obs_b1;
  logic        obs_busy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cur = 0; m_tgt = 0; m_guard = 0; m_starve = 0; m_uf = 0; m_starved = 0; m_r = '0;
    sa0 = {2{MID}}; sa1 = {2{MID}}; ea0 = {2{MID}}; ea1 = {2{MID}};
    sb0 = {3{MID}}; sb1 = {3{MID}}; eb0 = {3{MID}}; eb1 = {3{MID}};
  endtask

  task automatic model_step();
    bit run_now;
    bit trip;
    ea0 = sa0; ea1 = sa1; eb0 = sb0; eb1 = sb1;
    run_now = (m_guard == 0) && (m_cur == 1);
    if (run_now) begin
      if (in_valid) begin
        sa0 = d0a ^ {2{MID}}; sa1 = d1a ^ {2{MID}};
        sb0 = d0b;            sb1 = d1b;
      end
    end else if (m_guard == 0 && m_cur == 2) begin
      sa0 = {2{m_r}}; sa1 = {2{16'(m_r + 16'd1)}};
      sb0 = {3{m_r}}; sb1 = {3{16'(m_r + 16'd1)}};
      m_r = m_r + 16'd2;
    end else begin
      sa0 = {2{MID}}; sa1 = {2{MID}}; sb0 = {3{MID}}; sb1 = {3{MID}};
    end
    trip = 1'b0;
    if (run_now && !in_valid) begin
      if (m_uf < 65535) m_uf++;
      m_starve++;
      trip = (m_starve == STARVE_LIM);
    end else begin
      m_starve = 0;
    end
    if (mode_stb) begin
      m_tgt     = (mode == 2'd1) ? 1 : ((mode == 2'd2) ? 2 : 0);
      m_guard   = GUARD_LEN;
      m_starved = 1'b0;
    end else if (m_guard > 0) begin
      m_guard--;
      if (m_guard == 0) begin
        m_cur = m_tgt;
        m_r   = '0;
      end
    end else if (trip) begin
      m_cur     = 0;
      m_starved = 1'b1;
    end
  endtask

  task automatic rnd_data();
    d0a = $urandom; d1a = $urandom;
    d0b = {16'($urandom), $urandom}; d1b = {16'($urandom), $urandom};
  endtask

  // One clock: apply inputs, step model at posedge, check both halves of the DDR output.
  task automatic cyc(input bit stb, input logic [1:0] md, input bit vld);
    mode_stb = stb; mode = md; in_valid = vld;
    @(posedge clk);
    model_step();
    #1;
    obs_a0 = dac_a; obs_b0 = dac_b; obs_busy = busy_a;
    chk("dac_a_h0", 64'(dac_a), 64'(ea0));
    chk("dac_b_h0", 64'(dac_b), 64'(eb0));
    chk("busy_a", 64'(busy_a), 64'(m_guard > 0));
    chk("busy_b", 64'(busy_b), 64'(m_guard > 0));
    chk("starved_a", 64'(starved_a), 64'(m_starved));
    chk("starved_b", 64'(starved_b), 64'(m_starved));
    chk("uf_a", 64'(uf_a), 64'(m_uf));
    chk("uf_b", 64'(uf_b), 64'(m_uf));
    @(negedge clk);
    #1;
    obs_a1 = dac_a; obs_b1 = dac_b;
    chk("dac_a_h1", 64'(dac_a), 64'(ea1));
    chk("dac_b_h1", 64'(dac_b), 64'(eb1));
    mode_stb = 1'b0;
  endtask

  initial begin
    int  busy_cnt;
    int  burst;
    bit  saw_ffff;
    bit  wrap_done;

    model_reset();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_dac_a", 64'(dac_a), 64'({2{MID}}));
    chk("rst_dac_b", 64'(dac_b), 64'({3{MID}}));
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_starved", 64'(starved_a), 64'd0);
    chk("rst_uf", 64'(uf_b), 64'd0);
    @(negedge clk); #1 rst_n = 1'b1;

    repeat (3) begin rnd_data(); cyc(1'b0, 2'd0, 1'b1); end

    // Guard into RUN, then the known sign-conversion pair.
    cyc(1'b1, 2'd1, 1'b0);
    repeat (8) begin rnd_data(); cyc(1'b0, 2'd0, 1'b1); end
    d0a = '0; d1a = '1; d0b = '0; d1b = '1;
    cyc(1'b0, 2'd0, 1'b1);
    rnd_data();
    cyc(1'b0, 2'd0, 1'b1);
    chk("plan_a_h0", 64'(obs_a0), 64'h8000_8000);
    chk("plan_a_h1", 64'(obs_a1), 64'h7FFF_7FFF);
    chk("plan_b_h0", 64'(obs_b0), 64'h0);
    chk("plan_b_h1", 64'(obs_b1), 64'hFFFF_FFFF_FFFF);
    repeat (20) begin rnd_data(); cyc(1'b0, 2'd0, 1'b1); end

    // Short starvation holds, longer starvation auto-mutes.
    repeat (5) begin rnd_data(); cyc(1'b0, 2'd0, 1'b0); end
    chk("uf_after5", 64'(uf_a), 64'd5);
    chk("no_starve5", 64'(starved_a), 64'd0);
    repeat (11) begin rnd_data(); cyc(1'b0, 2'd0, 1'b0); end
    chk("starve_trip_a", 64'(starved_a), 64'd1);
    chk("starve_trip_b", 64'(starved_b), 64'd1);
    repeat (3) begin rnd_data(); cyc(1'b0, 2'd0, 1'b1); end
    chk("muted_after_trip", 64'(obs_a0), 64'({2{MID}}));

    // Strobe coinciding with the trip cycle keeps starved clear.
    cyc(1'b1, 2'd1, 1'b1);
    repeat (11) begin rnd_data(); cyc(1'b0, 2'd0, 1'b1); end
    repeat (15) begin rnd_data(); cyc(1'b0, 2'd0, 1'b0); end
    cyc(1'b1, 2'd1, 1'b0);
    chk("stb_beats_trip", 64'(starved_a), 64'd0);
    repeat (12) begin rnd_data(); cyc(1'b0, 2'd0, 1'b1); end

    // TEST ramp through a full wrap.
    cyc(1'b1, 2'd2, 1'b1);
    repeat (10) begin rnd_data(); cyc(1'b0, 2'd0, 1'b1); end
    chk("ramp0_a", 64'(obs_a0), 64'h0);
    chk("ramp1_a", 64'(obs_a1), 64'h0001_0001);
    chk("ramp1_b", 64'(obs_b1), 64'h0001_0001_0001);
    saw_ffff = 1'b0; wrap_done = 1'b0;
    for (int i = 0; i < 32800; i++) begin
      rnd_data();
      cyc(1'b0, 2'd0, 1'($urandom_range(0, 1)));
      if (saw_ffff && !wrap_done) begin
        chk("ramp_wrap", 64'(obs_a0[15:0]), 64'h0);
        wrap_done = 1'b1;
      end
      if (obs_a1[15:0] == 16'hFFFF) saw_ffff = 1'b1;
    end
    chk("ramp_wrap_seen", 64'(wrap_done), 64'd1);

    // Strobe during guard restarts it and retargets.
    cyc(1'b1, 2'd1, 1'b1);
    repeat (3) cyc(1'b0, 2'd0, 1'b1);
    cyc(1'b1, 2'd2, 1'b1);
    busy_cnt = obs_busy ? 1 : 0;
    repeat (11) begin
      cyc(1'b0, 2'd0, 1'b1);
      if (obs_busy) busy_cnt++;
    end
    chk("guard_restart_len", 64'(busy_cnt), 64'd8);
    chk("ends_in_test", 64'(obs_a0), 64'h0002_0002);

    // Asynchronous reset in the middle of a TEST high phase.
    repeat (4) cyc(1'b0, 2'd0, 1'b1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("arst_dac_a", 64'(dac_a), 64'({2{MID}}));
    chk("arst_dac_b", 64'(dac_b), 64'({3{MID}}));
    chk("arst_uf", 64'(uf_a), 64'd0);
    chk("arst_busy", 64'(busy_a), 64'd0);
    chk("arst_starved", 64'(starved_b), 64'd0);
    model_reset();
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (4) begin rnd_data(); cyc(1'b0, 2'd0, 1'b1); end

    // Randomised mix of strobes, modes (including code 3) and starvation bursts.
    burst = 0;
    for (int i = 0; i < 800; i++) begin
      bit vld;
      rnd_data();
      if (burst == 0 && $urandom_range(0, 39) == 0) burst = $urandom_range(10, 20);
      vld = (burst > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (burst > 0) burst--;
      cyc($urandom_range(0, 29) == 0, 2'($urandom_range(0, 3)), vld);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
